inv_substitution_seq: RTL and testbench

INV_SUBSTITUTION_SEQ -- requirements
Module: inv_substitution_seq

---
 rtl/inv_substitution_seq.sv | 106 ++++++++++
 tb/tb_inv_substitution_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_substitution_seq.sv
// Inverse ASCON S-box over the 64 five-bit state columns, COLS_PER_CYCLE columns per clock.
// Latency 64/COLS_PER_CYCLE edges after acceptance; ready_o is low while busy and starts are then dropped.
package ascon_pack;
    typedef logic [4:0][63:0] type_state;
endpackage

module inv_substitution_seq
    import ascon_pack::*;
#(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state state_i,
    output logic      ready_o,
    output logic      done_o,
    output type_state state_o
);

    localparam int NUM_CHUNKS = 64 / COLS_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    type_state        state_q, state_d;
    logic [63:0][4:0] inv_col;

    function automatic logic [4:0] inv5(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h14;  5'h01: y = 5'h1a;  5'h02: y = 5'h07;  5'h03: y = 5'h0d;
            5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0e;  5'h07: y = 5'h12;
            5'h08: y = 5'h0a;  5'h09: y = 5'h06;  5'h0a: y = 5'h1d;  5'h0b: y = 5'h01;
            5'h0c: y = 5'h19;  5'h0d: y = 5'h15;  5'h0e: y = 5'h13;  5'h0f: y = 5'h1e;
            5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0b;  5'h13: y = 5'h11;
            5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1c;  5'h17: y = 5'h1f;
            5'h18: y = 5'h17;  5'h19: y = 5'h1b;  5'h1a: y = 5'h04;  5'h1b: y = 5'h08;
            5'h1c: y = 5'h0f;  5'h1d: y = 5'h0c;  5'h1e: y = 5'h10;  default: y = 5'h02;
        endcase
        return y;
    endfunction

    // Word 0 supplies the column MSB.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            inv_col[i] = inv5({state_q[0][i], state_q[1][i], state_q[2][i],
                               state_q[3][i], state_q[4][i]});
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = state_i;
                    cnt_d   = '0;
                    fsm_d   = BUSY;
                end else begin
                    fsm_d = IDLE;
                end
            end
            BUSY: begin
                // Each column compares its fixed chunk index against the counter, avoiding a shifter.
                for (int i = 0; i < 64; i++) begin
                    if (cnt_q == CNT_W'(i / COLS_PER_CYCLE)) begin
                        for (int r = 0; r < 5; r++) begin
                            state_d[r][i] = inv_col[i][4-r];
                        end
                    end
                end
                if (cnt_q == LAST_CHUNK) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign ready_o = (fsm_q != BUSY);
    assign done_o  = (fsm_q == DONE);
    assign state_o = state_q;

endmodule

// File: tb/tb_inv_substitution_seq.sv
// Directed bench for inv_substitution_seq at 8, 1, 16 and 64 columns per cycle running side by side.
module tb_inv_substitution_seq;
    import ascon_pack::*;

    logic      clock_i = 1'b0;
    logic      reset_i = 1'b1;
    logic      start_i = 1'b0;
    type_state st_i    = '0;
    logic      rdy [4];
    logic      dn  [4];
    type_state so  [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        type_state in_s;
        type_state exp_s;
    } vec_t;

    always #5 clock_i = ~clock_i;

    inv_substitution_seq #(.COLS_PER_CYCLE(8)) u_c8 (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .state_i(st_i),
        .ready_o(rdy[0]), .done_o(dn[0]), .state_o(so[0]));
    inv_substitution_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .state_i(st_i),
        .ready_o(rdy[1]), .done_o(dn[1]), .state_o(so[1]));
    inv_substitution_seq #(.COLS_PER_CYCLE(16)) u_c16 (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .state_i(st_i),
        .ready_o(rdy[2]), .done_o(dn[2]), .state_o(so[2]));
    inv_substitution_seq #(.COLS_PER_CYCLE(64)) u_c64 (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .state_i(st_i),
        .ready_o(rdy[3]), .done_o(dn[3]), .state_o(so[3]));

    function automatic int cols_of(input int k);
        case (k)
            0: return 8;
            1: return 1;
            2: return 16;
            default: return 64;
        endcase
    endfunction

    function automatic logic [4:0] fwd5(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
            5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
            5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
            5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
            5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
            5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
        endcase
        return y;
    endfunction

    function automatic type_state mk(input logic [63:0] w0, input logic [63:0] w1,
                                     input logic [63:0] w2, input logic [63:0] w3,
                                     input logic [63:0] w4);
        return {w4, w3, w2, w1, w0};
    endfunction

    function automatic type_state set_col(input type_state s, input int i, input logic [4:0] v);
        type_state t;
        t = s;
        for (int r = 0; r < 5; r++) t[r][i] = v[4-r];
        return t;
    endfunction

    function automatic type_state fwd_state(input type_state s);
        type_state t;
        t = s;
        for (int i = 0; i < 64; i++)
            t = set_col(t, i, fwd5({s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}));
        return t;
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm, input type_state act, input type_state exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction on all four instances; state_i is scrambled after acceptance.
    task automatic run_vec(input type_state in_s, input type_state exp_s, input int id);
        int  lat  [4];
        bit  seen [4];
        st_i    = in_s;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        st_i    = ~in_s;
        check_bit($sformatf("v%0d_busy_ready", id), rdy[0], 1'b0);
        check_bit($sformatf("v%0d_busy_done", id), dn[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            lat[k]  = 0;
            seen[k] = 1'b0;
        end
        for (int c = 1; c <= 70; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (dn[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = c;
                    check_state($sformatf("v%0d_c%0d_result", id, cols_of(k)), so[k], exp_s);
                end
            end
        end
        for (int k = 0; k < 4; k++)
            check_int($sformatf("v%0d_c%0d_latency", id, cols_of(k)), lat[k], 64 / cols_of(k));
        check_state($sformatf("v%0d_idle_hold", id), so[0], exp_s);
        check_bit($sformatf("v%0d_idle_ready", id), rdy[0], 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      vecs [3];
        type_state zexp;
        type_state orig;
        type_state exh_in;
        type_state exh_exp;
        logic [4:0] inv_tab [32];
        bit        exp_pulse;
        int        n_done;

        inv_tab = '{5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
                    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
                    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
                    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};
        zexp = mk(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0);
        orig = mk(64'heeea8c8972cc93fd, 64'hff9e7f5bbb51cb2a, 64'hd043ab88a97926c5,
                  64'hf8bda5cbfdf4f6b4, 64'h221f7efb7af94591);
        exh_in  = '0;
        exh_exp = '0;
        for (int i = 0; i < 64; i++) begin
            exh_in  = set_col(exh_in, i, 5'(i % 32));
            exh_exp = set_col(exh_exp, i, inv_tab[i % 32]);
        end
        vecs[0] = '{in_s: '0, exp_s: zexp};
        vecs[1] = '{in_s: fwd_state(orig), exp_s: orig};
        vecs[2] = '{in_s: exh_in, exp_s: exh_exp};

        // Reset state, held with start low.
        tick();
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_bit($sformatf("reset_ready_c%0d", cols_of(k)), rdy[k], 1'b1);
            check_bit($sformatf("reset_done_c%0d", cols_of(k)), dn[k], 1'b0);
            check_state($sformatf("reset_state_c%0d", cols_of(k)), so[k], '0);
        end

        for (int v = 0; v < 3; v++)
            run_vec(vecs[v].in_s, vecs[v].exp_s, v);

        // start held high: accept every 9 cycles, ready only in DONE.
        st_i    = '0;
        start_i = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            tick();
            exp_pulse = (s == 9) || (s == 18);
            check_bit($sformatf("hold_s%0d_done", s), dn[0], exp_pulse);
            check_bit($sformatf("hold_s%0d_ready", s), rdy[0], exp_pulse);
            if (exp_pulse)
                check_state($sformatf("hold_s%0d_result", s), so[0], zexp);
        end
        start_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;

        // Reset with the default instance at counter 3.
        st_i    = fwd_state(orig);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_bit("abort_ready", rdy[0], 1'b1);
        check_bit("abort_done", dn[0], 1'b0);
        check_state("abort_state", so[0], '0);
        check_bit("abort_done_c16", dn[2], 1'b0);
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dn[0]) n_done++;
        end
        check_int("abort_no_pulse", n_done, 0);
        run_vec(vecs[1].in_s, vecs[1].exp_s, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
